// File: rtl/or_unit_arbiter_pkg.sv
// Shared definitions for the round-robin OR-unit arbiter: FSM state encoding and
// default sizing.
package or_unit_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EXEC = 2'd2
  } state_t;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/or_vec.sv
// Shared OR datapath: one gate primitive per bit, purely combinational.
module or_vec #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    or u_or (y[i], a[i], b[i]);
  end

endmodule

// File: rtl/or_unit_arbiter.sv
// Round-robin arbiter that time-multiplexes a single OR datapath among NREQ
// requesters: grant, capture operands, compute, then pulse done with the result.
module or_unit_arbiter
  import or_unit_arbiter_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] op_a,
  input  logic [NREQ*WIDTH-1:0] op_b,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic [WIDTH-1:0]      result,
  output logic [NREQ-1:0]       done
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            state_r, state_n;
  logic [NREQ-1:0]   gnt_r, gnt_n;
  logic [NREQ-1:0]   done_r, done_n;
  logic              busy_r, busy_n;
  logic [IDXW-1:0]   last_r, last_n;
  logic [WIDTH-1:0]  opa_r, opb_r;
  logic [WIDTH-1:0]  result_r;
  logic [WIDTH-1:0]  or_y;
  logic [IDXW-1:0]   win;
  logic              load_ops;
  logic              load_result;

  // First set request bit scanning upward from last+1, wrapping modulo NREQ.
  function automatic logic [IDXW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [IDXW-1:0] last);
    logic [IDXW-1:0] pick;
    logic [IDXW-1:0] idx;
    pick = last;
    for (int i = NREQ; i >= 1; i--) begin
      idx = IDXW'((int'(last) + i) % NREQ);
      if (r[idx]) begin
        pick = idx;
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IDXW-1:0] idx);
    return {{(NREQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  or_vec #(.WIDTH(WIDTH)) u_or_vec (
    .a(opa_r),
    .b(opb_r),
    .y(or_y)
  );

  // Next-state and next-output decode.
  always_comb begin
    state_n     = state_r;
    gnt_n       = '0;
    done_n      = '0;
    busy_n      = 1'b0;
    last_n      = last_r;
    load_ops    = 1'b0;
    load_result = 1'b0;
    win         = rr_pick(req, last_r);
    case (state_r)
      ST_IDLE: begin
        if (|req) begin
          state_n = ST_LOAD;
          gnt_n   = onehot(win);
          last_n  = win;
          busy_n  = 1'b1;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_n  = ST_EXEC;
        busy_n   = 1'b1;
        load_ops = 1'b1;
      end
      ST_EXEC: begin
        state_n     = ST_IDLE;
        done_n      = onehot(last_r);
        load_result = 1'b1;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State, pointer, operand and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      gnt_r    <= '0;
      done_r   <= '0;
      busy_r   <= 1'b0;
      last_r   <= IDXW'(NREQ - 1);
      opa_r    <= '0;
      opb_r    <= '0;
      result_r <= '0;
    end else begin
      state_r <= state_n;
      gnt_r   <= gnt_n;
      done_r  <= done_n;
      busy_r  <= busy_n;
      last_r  <= last_n;
      if (load_ops) begin
        opa_r <= op_a[int'(last_r)*WIDTH +: WIDTH];
        opb_r <= op_b[int'(last_r)*WIDTH +: WIDTH];
      end else begin
        opa_r <= opa_r;
        opb_r <= opb_r;
      end
      if (load_result) begin
        result_r <= or_y;
      end else begin
        result_r <= result_r;
      end
    end
  end

  assign gnt    = gnt_r;
  assign done   = done_r;
  assign busy   = busy_r;
  assign result = result_r;

endmodule

// File: tb/tb_or_unit_arbiter.sv
// Scoreboard bench for or_unit_arbiter: expected completions are queued as
// requests are driven and checked whenever done pulses.
module tb_or_unit_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [3:0]  gnt;
  logic        busy;
  logic [7:0]  result;
  logic [3:0]  done;

  typedef struct {
    int         idx;
    logic [7:0] res;
  } exp_t;

  exp_t exp_q[$];
  int   compared;
  int   mismatched;
  bit   mon_en;
  logic [7:0] prev_result;
  logic prev_rst;

  or_unit_arbiter #(.NREQ(4), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
    .gnt(gnt), .busy(busy), .result(result), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard and invariant monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (done !== 4'b0000) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL sb_unexpected_done done=%b result=%h expected no completion", done, result);
        end else begin
          exp_t e;
          logic [3:0] ed;
          e = exp_q.pop_front();
          ed = 4'b0001 << e.idx;
          if (done !== ed || result !== e.res) begin
            mismatched++;
            $display("FAIL sb_done done=%b result=%h expected done=%b result=%h", done, result, ed, e.res);
          end
        end
      end
      compared++;
      if (!$onehot0(gnt) || !$onehot0(done) || (gnt !== 4'b0000 && done !== 4'b0000)) begin
        mismatched++;
        $display("FAIL onehot_excl gnt=%b done=%b expected one-hot/zero and exclusive", gnt, done);
      end
      if (result !== prev_result && done === 4'b0000 && !prev_rst) begin
        compared++;
        mismatched++;
        $display("FAIL result_hold result=%h expected %h (no done, no reset)", result, prev_result);
      end
    end
    prev_result = result;
    prev_rst    = rst;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
    op_a[i*8 +: 8] = a;
    op_b[i*8 +: 8] = b;
  endtask

  task automatic push_exp(input int i, input logic [7:0] r);
    exp_t e;
    e.idx = i;
    e.res = r;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    logic [7:0] ta, tb;
    logic [3:0] eg;
    rst = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      ta = 8'h01 << i;
      tb = 8'h10 << i;
      set_ops(i, ta, tb);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      mon_en = 1'b1;
      compared++;
      if (gnt !== 4'b0000 || done !== 4'b0000 || result !== 8'h00 || busy !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_state gnt=%b done=%b result=%h busy=%b expected all zero", gnt, done, result, busy);
      end
    end
    for (int k = 0; k < 5; k++) begin
      ta = 8'h01 << (k % 4);
      tb = 8'h10 << (k % 4);
      push_exp(k % 4, ta | tb);
    end
    rst = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      step();
      eg = (c % 3 == 1 && c <= 13) ? (4'b0001 << ((c / 3) % 4)) : 4'b0000;
      compared++;
      if (gnt !== eg) begin
        mismatched++;
        $display("FAIL rr_order cycle=%0d gnt=%b expected %b", c, gnt, eg);
      end
      if (c % 3 != 0) begin
        compared++;
        if (done !== 4'b0000) begin
          mismatched++;
          $display("FAIL rr_done_spacing cycle=%0d done=%b expected 0000", c, done);
        end
      end
      if (c == 14) req = 4'b0000;
    end
  endtask

  task automatic test_single();
    set_ops(2, 8'hA0, 8'h05);
    push_exp(2, 8'hA5);
    req = 4'b0100;
    step();
    compared++;
    if (gnt !== 4'b0100 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL single_gnt gnt=%b busy=%b expected 0100 1", gnt, busy);
    end
    step();
    compared++;
    if (gnt !== 4'b0000 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL single_exec gnt=%b busy=%b expected 0000 1", gnt, busy);
    end
    req = 4'b0000;
    step();
    compared++;
    if (done !== 4'b0100 || result !== 8'hA5 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL single_done done=%b result=%h busy=%b expected 0100 a5 0", done, result, busy);
    end
    step();
    compared++;
    if (done !== 4'b0000) begin
      mismatched++;
      $display("FAIL single_pulse done=%b expected 0000", done);
    end
  endtask

  task automatic test_cancel();
    set_ops(0, 8'h0C, 8'h30);
    push_exp(0, 8'h3C);
    req = 4'b0001;
    step();
    compared++;
    if (gnt !== 4'b0001) begin
      mismatched++;
      $display("FAIL cancel_gnt0 gnt=%b expected 0001", gnt);
    end
    step();
    req = 4'b0010;
    step();
    req = 4'b0000;
    compared++;
    if (done !== 4'b0001 || result !== 8'h3C) begin
      mismatched++;
      $display("FAIL cancel_done0 done=%b result=%h expected 0001 3c", done, result);
    end
    for (int c = 4; c <= 6; c++) begin
      step();
      compared++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || done !== 4'b0000) begin
        mismatched++;
        $display("FAIL cancel_idle cycle=%0d gnt=%b busy=%b done=%b expected 0000 0 0000", c, gnt, busy, done);
      end
    end
  endtask

  task automatic test_mid_reset();
    set_ops(3, 8'hF0, 8'h0F);
    set_ops(0, 8'h81, 8'h18);
    req = 4'b1000;
    step();
    compared++;
    if (gnt !== 4'b1000) begin
      mismatched++;
      $display("FAIL midrst_gnt3 gnt=%b expected 1000", gnt);
    end
    step();
    rst = 1'b1;
    req = 4'b0000;
    step();
    compared++;
    if (done !== 4'b0000 || result !== 8'h00 || gnt !== 4'b0000 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL midrst_abort done=%b result=%h gnt=%b busy=%b expected 0000 00 0000 0", done, result, gnt, busy);
    end
    rst = 1'b0;
    req = 4'b1001;
    push_exp(0, 8'h99);
    push_exp(3, 8'hFF);
    step();
    compared++;
    if (gnt !== 4'b0001) begin
      mismatched++;
      $display("FAIL midrst_first_gnt gnt=%b expected 0001", gnt);
    end
    step();
    req = 4'b1000;
    step();
    step();
    compared++;
    if (gnt !== 4'b1000) begin
      mismatched++;
      $display("FAIL midrst_second_gnt gnt=%b expected 1000", gnt);
    end
    step();
    req = 4'b0000;
    step();
    step();
  endtask

  task automatic test_late_drop();
    set_ops(0, 8'h11, 8'h22);
    push_exp(0, 8'h33);
    req = 4'b0001;
    step();
    compared++;
    if (gnt !== 4'b0001 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL late_gnt gnt=%b busy=%b expected 0001 1", gnt, busy);
    end
    req = 4'b0000;
    step();
    step();
    compared++;
    if (done !== 4'b0001 || result !== 8'h33) begin
      mismatched++;
      $display("FAIL late_done done=%b result=%h expected 0001 33", done, result);
    end
    step();
    compared++;
    if (busy !== 1'b0 || gnt !== 4'b0000) begin
      mismatched++;
      $display("FAIL late_idle busy=%b gnt=%b expected 0 0000", busy, gnt);
    end
  endtask

  task automatic test_contention();
    logic [3:0] eg;
    set_ops(1, 8'h02, 8'h40);
    push_exp(1, 8'h42);
    req = 4'b0010;
    step();
    compared++;
    if (gnt !== 4'b0010) begin
      mismatched++;
      $display("FAIL cont_setup_gnt gnt=%b expected 0010", gnt);
    end
    req = 4'b0000;
    step();
    step();
    set_ops(3, 8'h80, 8'h01);
    set_ops(0, 8'h0A, 8'h50);
    push_exp(3, 8'h81);
    push_exp(0, 8'h5A);
    push_exp(1, 8'h42);
    req = 4'b1011;
    for (int d = 1; d <= 10; d++) begin
      step();
      case (d)
        1: eg = 4'b1000;
        4: eg = 4'b0001;
        7: eg = 4'b0010;
        default: eg = 4'b0000;
      endcase
      compared++;
      if (gnt !== eg) begin
        mismatched++;
        $display("FAIL cont_order cycle=%0d gnt=%b expected %b", d, gnt, eg);
      end
      if (d == 1) req = 4'b0011;
      if (d == 4) req = 4'b0010;
      if (d == 7) req = 4'b0000;
    end
  endtask

  task automatic test_drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      step();
      budget++;
    end
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL sb_drain pending=%0d expected 0", exp_q.size());
    end
  endtask

  initial begin
    compared    = 0;
    mismatched  = 0;
    mon_en      = 1'b0;
    prev_result = 8'h00;
    prev_rst    = 1'b1;
    rst         = 1'b1;
    req         = 4'b0000;
    op_a        = 32'h0;
    op_b        = 32'h0;
    test_reset();
    test_single();
    test_cancel();
    test_mid_reset();
    test_late_drop();
    test_contention();
    test_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
